// File: rtl/face_coord_uart_tx.sv
// Face-detection return path: queues detections in a FIFO and sends each one as a byte record over 8N1 UART,
// then sends an end-of-frame record with the detection count. Define FACE_TX_CHECKSUM_EN to append an XOR checksum byte.
module face_coord_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0][31:0] face_coords,
  input  logic             face_coords_ready,
  input  logic [3:0]       pyramid_number,
  input  logic             scan_done,
  output logic             tx,
  output logic             busy,
  output logic             overflow,
  output logic [15:0]      dropped_count,
  output logic [2:0]       o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef FACE_TX_CHECKSUM_EN
  localparam int DET_BYTES = 7;
  localparam int EOF_BYTES = 3;
`else
  localparam int DET_BYTES = 6;
  localparam int EOF_BYTES = 2;
`endif
  localparam int BUF_W = DET_BYTES * 8;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_REC = 3'd1;
  localparam logic [2:0] S_LOAD_EOF = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_DATA     = 3'd4;
  localparam logic [2:0] S_STOP     = 3'd5;

  function automatic logic [15:0] sat16(input logic [31:0] x);
    return (x[31:16] == 16'h0) ? x[15:0] : 16'hFFFF;
  endfunction

  logic [35:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [2:0]       r_state;
  logic [35:0]      r_rec;
  logic [7:0]       r_eof_cnt;
  logic [7:0]       r_frame_count;
  logic             r_eof_pending;
  logic [BUF_W-1:0] r_buf;
  logic [7:0]       r_cur;
  logic [2:0]       r_byte_idx;
  logic [2:0]       r_last_idx;
  logic [2:0]       r_bit_idx;
  logic [CW-1:0]    r_clk_cnt;
  logic             r_tx;
  logic             r_overflow;
  logic [15:0]      r_dropped;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_eof_start;
  logic w_bit_done;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_eof_start = (r_state == S_IDLE) && w_empty && r_eof_pending;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push      = face_coords_ready && (!w_full || w_pop);
  assign w_drop      = face_coords_ready && !w_push;
  assign w_bit_done  = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));

`ifdef FACE_TX_CHECKSUM_EN
  logic [7:0] w_det_csum;
  assign w_det_csum = {4'h0, r_rec[35:32]} ^ r_rec[31:24] ^ r_rec[23:16] ^ r_rec[15:8] ^ r_rec[7:0];
`endif

  always_ff @(posedge clock) begin
    if (w_push)
      r_mem[r_wr_ptr[AW-1:0]] <= {pyramid_number, sat16(face_coords[0]), sat16(face_coords[1])};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_overflow    <= 1'b0;
      r_dropped     <= 16'h0;
      r_eof_pending <= 1'b0;
      r_frame_count <= 8'h0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'h1;
      end
      // The count is handed to the EOF record this cycle; a detection accepted now belongs to the next frame.
      if (w_eof_start) begin
        r_eof_pending <= 1'b0;
        r_frame_count <= w_push ? 8'd1 : 8'd0;
      end else begin
        if (scan_done) r_eof_pending <= 1'b1;
        if (w_push)    r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rec      <= '0;
      r_eof_cnt  <= 8'h0;
      r_buf      <= '0;
      r_cur      <= 8'h0;
      r_byte_idx <= 3'd0;
      r_last_idx <= 3'd0;
      r_bit_idx  <= 3'd0;
      r_clk_cnt  <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_rec   <= r_mem[r_rd_ptr[AW-1:0]];
            r_state <= S_LOAD_REC;
          end else if (w_eof_start) begin
            r_eof_cnt <= r_frame_count;
            r_state   <= S_LOAD_EOF;
          end
        end
        S_LOAD_REC: begin
`ifdef FACE_TX_CHECKSUM_EN
          r_buf <= {w_det_csum, r_rec[7:0], r_rec[15:8], r_rec[23:16], r_rec[31:24],
                    4'h0, r_rec[35:32], 8'hA5};
`else
          r_buf <= {r_rec[7:0], r_rec[15:8], r_rec[23:16], r_rec[31:24], 4'h0, r_rec[35:32], 8'hA5};
`endif
          r_last_idx <= 3'(DET_BYTES - 1);
          r_byte_idx <= 3'd0;
          r_clk_cnt  <= '0;
          r_tx       <= 1'b0;
          r_state    <= S_START;
        end
        S_LOAD_EOF: begin
`ifdef FACE_TX_CHECKSUM_EN
          r_buf <= {{(BUF_W - EOF_BYTES * 8){1'b0}}, r_eof_cnt, r_eof_cnt, 8'h5A};
`else
          r_buf <= {{(BUF_W - EOF_BYTES * 8){1'b0}}, r_eof_cnt, 8'h5A};
`endif
          r_last_idx <= 3'(EOF_BYTES - 1);
          r_byte_idx <= 3'd0;
          r_clk_cnt  <= '0;
          r_tx       <= 1'b0;
          r_state    <= S_START;
        end
        S_START: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            r_tx      <= r_buf[0];
            r_cur     <= {1'b0, r_buf[7:1]};
            r_bit_idx <= 3'd0;
            r_state   <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_tx      <= r_cur[0];
              r_cur     <= {1'b0, r_cur[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            if (r_byte_idx == r_last_idx) begin
              r_state <= S_IDLE;
            end else begin
              r_byte_idx <= r_byte_idx + 3'd1;
              r_buf      <= r_buf >> 8;
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx            = r_tx;
  assign busy          = !w_empty || r_eof_pending || (r_state != S_IDLE);
  assign overflow      = r_overflow;
  assign dropped_count = r_dropped;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_face_coord_uart_tx.sv
// Directed bench for face_coord_uart_tx: a UART receiver decodes tx and compares bytes against an expected queue.
module tb_face_coord_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [1:0][31:0] face_coords = '0;
  logic             face_coords_ready = 1'b0;
  logic [3:0]       pyramid_number = 4'h0;
  logic             scan_done = 1'b0;
  logic             tx;
  logic             busy;
  logic             overflow;
  logic [15:0]      dropped_count;
  logic [2:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  face_coord_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .face_coords(face_coords),
    .face_coords_ready(face_coords_ready), .pyramid_number(pyramid_number),
    .scan_done(scan_done), .tx(tx), .busy(busy), .overflow(overflow),
    .dropped_count(dropped_count), .o_dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_det(input logic [7:0] pyr, input logic [7:0] rh, input logic [7:0] rl,
                         input logic [7:0] ch, input logic [7:0] cl);
    exp_q.push_back(8'hA5); exp_q.push_back(pyr);
    exp_q.push_back(rh); exp_q.push_back(rl); exp_q.push_back(ch); exp_q.push_back(cl);
`ifdef FACE_TX_CHECKSUM_EN
    exp_q.push_back(pyr ^ rh ^ rl ^ ch ^ cl);
`endif
  endtask

  task automatic exp_eof(input logic [7:0] cnt);
    exp_q.push_back(8'h5A); exp_q.push_back(cnt);
`ifdef FACE_TX_CHECKSUM_EN
    exp_q.push_back(cnt);
`endif
  endtask

  // Drives one cycle of inputs starting at the next falling edge; chain calls for back-to-back strobes.
  task automatic pulse(input logic rdy, input logic [3:0] pyr, input logic [31:0] row,
                       input logic [31:0] col, input logic sd);
    @(negedge clock);
    face_coords[0]    = row;
    face_coords[1]    = col;
    pyramid_number    = pyr;
    face_coords_ready = rdy;
    scan_done         = sd;
  endtask

  task automatic release_inputs();
    @(negedge clock);
    face_coords_ready = 1'b0;
    scan_done         = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, (n >= budget) ? 32'd1 : 32'd0, 32'd0);
    repeat (4) @(negedge clock);
  endtask

  // Receiver: starts on a low tx seen at a falling edge, samples each bit at its centre.
  initial begin : rx_proc
    logic [7:0] b;
    logic ab;
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && tx === 1'b0) begin
        b  = 8'h0;
        ab = 1'b0;
        for (int n = 1; n <= CPB / 2 + 9 * CPB; n++) begin
          @(negedge clock);
          if (reset !== 1'b0) ab = 1'b1;
          if (n >= CPB / 2 + CPB && n < CPB / 2 + 9 * CPB && ((n - CPB / 2) % CPB) == 0)
            b[(n - CPB / 2) / CPB - 1] = tx;
        end
        if (!ab) begin
          check("rx_stop", {31'd0, tx}, 32'd1);
          if (exp_q.size() == 0) check("rx_extra", {24'd0, b}, 32'hFFFF_FFFF);
          else                   check("rx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    // Reset values
    repeat (3) @(negedge clock);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_drop", {16'd0, dropped_count}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Basic record and latency: strobe at edge N, tx low from edge N+2
    exp_det(8'h02, 8'h00, 8'h03, 8'h01, 8'h2C);
    pulse(1'b1, 4'd2, 32'd3, 32'd300, 1'b0);
    release_inputs();
    check("busy_after_strobe", {31'd0, busy}, 32'd1);
    @(negedge clock);
    check("tx_n1", {31'd0, tx}, 32'd1);
    @(negedge clock);
    check("tx_n2", {31'd0, tx}, 32'd0);
    wait_idle("idle_s1", 500);
    check("busy_s1", {31'd0, busy}, 32'd0);

    // Saturated row, then EOF for the two detections so far
    exp_det(8'h05, 8'hFF, 8'hFF, 8'h00, 8'h07);
    pulse(1'b1, 4'd5, 32'h0001_0005, 32'd7, 1'b0);
    release_inputs();
    wait_idle("idle_s2", 500);
    exp_eof(8'd2);
    pulse(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    release_inputs();
    wait_idle("idle_s2_eof", 300);

    // Three detections in order, then EOF 3, then an empty frame
    exp_det(8'h01, 8'h00, 8'h0A, 8'h00, 8'h14);
    exp_det(8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD);
    exp_det(8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    exp_eof(8'd3);
    pulse(1'b1, 4'd1, 32'd10, 32'd20, 1'b0);
    pulse(1'b1, 4'd3, 32'h1234, 32'hABCD, 1'b0);
    pulse(1'b1, 4'hF, 32'hFFFF, 32'h0001_0000, 1'b0);
    pulse(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    release_inputs();
    wait_idle("idle_s3", 1500);
    exp_eof(8'd0);
    pulse(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    release_inputs();
    wait_idle("idle_s3_eof", 300);
    check("ovf_before", {31'd0, overflow}, 32'd0);

    // Overflow: seven back-to-back strobes, five accepted, two dropped
    for (int i = 1; i <= 5; i++)
      exp_det(8'(i), 8'h00, 8'(i), 8'h01, 8'(i));
    exp_eof(8'd5);
    for (int i = 1; i <= 7; i++)
      pulse(1'b1, 4'(i), 32'(i), 32'(256 + i), 1'b0);
    release_inputs();
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_count", {16'd0, dropped_count}, 32'd2);
    pulse(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    release_inputs();
    wait_idle("idle_s4", 2500);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("drop_hold", {16'd0, dropped_count}, 32'd2);

    // scan_done together with a detection on an empty FIFO
    exp_det(8'h09, 8'h00, 8'h80, 8'hFF, 8'hFF);
    exp_eof(8'd1);
    pulse(1'b1, 4'd9, 32'h80, 32'h0200_0000, 1'b1);
    release_inputs();
    wait_idle("idle_s5", 600);

    // Reset during the data bits of the fourth byte
    exp_q.push_back(8'hA5); exp_q.push_back(8'h06); exp_q.push_back(8'hBE);
    pulse(1'b1, 4'd6, 32'h0000_BEEF, 32'h1234, 1'b0);
    release_inputs();
    repeat (142) @(negedge clock);
    reset = 1'b1;
    #1;
    check("arst_tx", {31'd0, tx}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ovf", {31'd0, overflow}, 32'd0);
    check("arst_drop", {16'd0, dropped_count}, 32'd0);
    check("arst_state", {29'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    check("post_rst_q", exp_q.size(), 32'd0);
    exp_det(8'h04, 8'h00, 8'h02, 8'h00, 8'h01);
    exp_eof(8'd1);
    pulse(1'b1, 4'd4, 32'd2, 32'd1, 1'b0);
    pulse(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    release_inputs();
    wait_idle("idle_s6", 600);

    repeat (10) @(negedge clock);
    check("exp_left", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
